mdu_issue_ctrl: RTL and testbench

- Requester-side controller for the E-stage multiply/divide unit.
- Sits between D-stage decode and the MDU. Accepts MD-class instructions leaving D, drives the MDU start pulse and operation code into E, and tracks the outstanding operation with its own latency counter.
- Generates the D-stage stall for every MD-class instruction while an operation is outstanding.
- Handles exception/interrupt flush (Req) and signals result commit.

---
 rtl/mdu_issue_ctrl.sv | 123 ++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// MDU requester: issues MD ops from D into E, stalls D while an
// arithmetic op is outstanding and pulses commit when HI/LO land.
module mdu_issue_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CW       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Req,
  input  logic          d_valid,
  input  logic [3:0]    d_op,
  input  logic          d_advance,
  output logic          stall,
  output logic          e_start,
  output logic [3:0]    e_op,
  output logic          busy,
  output logic          commit,
  output logic [CW-1:0] cnt_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_DONE
  } state_e;

  localparam logic [CW-1:0] LAT_M = CW'(MULT_LAT);
  localparam logic [CW-1:0] LAT_D = CW'(DIV_LAT);
  localparam logic [CW-1:0] ONE   = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    e_op_q, e_op_d;
  logic          e_start_q, e_start_d;

  logic md, arith, mul, issue, outst;

  always_comb begin
    md    = 1'b0;
    arith = 1'b0;
    mul   = 1'b0;
    unique case (1'b1)
      (d_op == 4'd1 || d_op == 4'd2): begin
        md    = 1'b1;
        arith = 1'b1;
        mul   = 1'b1;
      end
      (d_op == 4'd3 || d_op == 4'd4): begin
        md    = 1'b1;
        arith = 1'b1;
      end
      (d_op >= 4'd5 && d_op <= 4'd8): begin
        md    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    outst     = (state_q == S_ISSUE) ||
                (state_q == S_BUSY);
    stall     = d_valid && md && outst;
    issue     = d_valid && md && d_advance &&
                !stall && !Req;
    e_op_d    = issue ? d_op : 4'd0;
    e_start_d = issue && arith;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (issue && arith) begin
          state_d = S_ISSUE;
          cnt_d   = mul ? LAT_M : LAT_D;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        // Only an op still in E can be cancelled by a flush
        if (Req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - ONE;
          state_d = (cnt_q == ONE) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d   = cnt_q - ONE;
        state_d = (cnt_q == ONE) ? S_DONE : S_BUSY;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      e_op_q    <= '0;
      e_start_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      e_op_q    <= e_op_d;
      e_start_q <= e_start_d;
    end
  end

  assign e_start = e_start_q;
  assign e_op    = e_op_q;
  assign busy    = (state_q == S_ISSUE) ||
                   (state_q == S_BUSY);
  assign commit  = (state_q == S_DONE);
  assign cnt_out = cnt_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: directed scenarios plus random traffic
// against a cycle-index model of the outstanding operation.
module tb_mdu_issue_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int CW       = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          Req;
  logic          d_valid;
  logic [3:0]    d_op;
  logic          d_advance;
  logic          stall;
  logic          e_start;
  logic [3:0]    e_op;
  logic          busy;
  logic          commit;
  logic [CW-1:0] cnt_out;

  mdu_issue_ctrl #(
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT),
    .CW      (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Req      (Req),
    .d_valid  (d_valid),
    .d_op     (d_op),
    .d_advance(d_advance),
    .stall    (stall),
    .e_start  (e_start),
    .e_op     (e_op),
    .busy     (busy),
    .commit   (commit),
    .cnt_out  (cnt_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: an op sits in E at cycle iss, is busy for lat cycles,
  // and commits at cycle iss+lat.
  int cyc     = 0;
  bit have_op = 0;
  int iss     = 0;
  int lat     = 0;
  int x_eop   = 0;
  int x_est   = 0;
  int n_commit = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input logic v, input logic [3:0] op,
                      input logic adv, input logic rq);
    bit m_md, m_ar, m_busy, m_com, m_stall, m_iss;
    int m_cnt;
    d_valid   = v;
    d_op      = op;
    d_advance = adv;
    Req       = rq;
    #4;
    m_md    = (op >= 1) && (op <= 8);
    m_ar    = (op >= 1) && (op <= 4);
    m_busy  = have_op && (cyc >= iss) && (cyc < iss + lat);
    m_com   = have_op && (cyc == iss + lat);
    m_cnt   = m_busy ? (iss + lat - cyc) : 0;
    m_stall = v && m_md && m_busy;
    m_iss   = v && m_md && adv && !m_stall && !rq;
    chk("stall",   stall,   m_stall);
    chk("busy",    busy,    m_busy);
    chk("commit",  commit,  m_com);
    chk("cnt_out", cnt_out, m_cnt);
    chk("e_op",    e_op,    x_eop);
    chk("e_start", e_start, x_est);
    if (commit) n_commit++;
    if (have_op && cyc == iss && rq) have_op = 0;
    if (m_com) have_op = 0;
    if (m_iss && m_ar) begin
      have_op = 1;
      iss     = cyc + 1;
      lat     = (op <= 2) ? MULT_LAT : DIV_LAT;
    end
    x_eop = m_iss ? int'(op) : 0;
    x_est = (m_iss && m_ar) ? 1 : 0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 4'd0, 1, 0);
  endtask

  initial begin
    int c0;
    reset = 0; Req = 0; d_valid = 0;
    d_op = 0; d_advance = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   busy,    0);
    chk("rst_eop",    e_op,    0);
    chk("rst_estart", e_start, 0);
    chk("rst_commit", commit,  0);
    chk("rst_cnt",    cnt_out, 0);
    reset = 1;

    // mult issue and completion
    tick(1, 4'd1, 1, 0);
    chk("mult_estart", e_start, 1);
    chk("mult_eop",    e_op,    1);
    idle(7);

    // mflo held behind div
    tick(1, 4'd3, 1, 0);
    for (int i = 0; i < 11; i++) tick(1, 4'd6, 1, 0);
    chk("mflo_eop", e_op, 6);
    idle(3);

    // flush while mult is in E
    c0 = n_commit;
    tick(1, 4'd1, 1, 0);
    tick(0, 4'd0, 1, 1);
    chk("flush_busy", busy, 0);
    idle(8);
    chk("flush_nocommit", n_commit, c0);

    // Req during BUSY is ignored
    tick(1, 4'd4, 1, 0);
    for (int i = 1; i <= 13; i++)
      tick(0, 4'd0, 1, (i == 4));

    // back-to-back multu then div, then mthi while idle
    tick(1, 4'd2, 1, 0);
    for (int i = 0; i < 6; i++) tick(1, 4'd3, 1, 0);
    chk("b2b_eop", e_op, 3);
    idle(11);
    tick(1, 4'd7, 1, 0);
    chk("mthi_busy", busy, 0);
    idle(2);

    // issue suppressed by d_advance=0
    tick(1, 4'd1, 0, 0);
    idle(2);

    // async reset mid-BUSY, then opcode 12
    c0 = n_commit;
    tick(1, 4'd4, 1, 0);
    idle(3);
    chk("pre_rst_busy", busy, 1);
    #2 reset = 0;
    #1;
    chk("arst_busy",   busy,    0);
    chk("arst_estart", e_start, 0);
    chk("arst_eop",    e_op,    0);
    chk("arst_cnt",    cnt_out, 0);
    chk("arst_commit", commit,  0);
    have_op = 0; x_eop = 0; x_est = 0;
    @(posedge clk);
    #2 reset = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) tick(1, 4'd12, 1, 0);
    chk("arst_nocommit", n_commit, c0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 9) == 0));
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
